// File: rtl/ccd_pixel_sink.sv
// ccd_pixel_sink: takes 16-bit CCD pixel words over the avail/accept level handshake and streams them out as little-endian bytes.
// Latency: the word is written 3 clk after data_avail rises; the first byte is valid 1 clk later; 2 clk per word at the byte port.
// Backpressure: a stall on out_ready fills the FIFO, data_accept is then withheld, and the readout stops clocking.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   clear             synchronous flush of the FIFO, counters, flags and handshake state
//   data_in           pixel word, stable for the whole data_avail window
//   data_avail        readout word-valid level (module_clk domain, synchronized here)
//   data_accept       registered acceptance level back to the readout
//   out_data          byte to host; out_valid/out_ready handshake
//   out_valid         out_data holds a byte for the host
//   out_ready         host takes the byte when both this and out_valid are high
//   fifo_level        words held, including the one being serialized
//   pixel_count       words written since reset/clear, wraps
//   overrun           sticky: a window closed before its word could be written
module ccd_pixel_sink #(
   parameter int FIFO_AW = 4,
   parameter int CNT_W   = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic [15:0]        data_in,
   input  logic               data_avail,
   output logic               data_accept,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [CNT_W-1:0]   pixel_count,
   output logic               overrun
);

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   LVL_TWO  = (FIFO_AW+1)'(2);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // data_avail synchronizer and edge detect
   // ------------------------------------------------------------------
   logic av_meta;
   logic av_s;
   logic av_d;
   logic rise;

   // av_d follows av_s on every cycle, clear included: after a flush a
   // window that is already open looks like a steady level, not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         av_meta <= 1'b0;
         av_s    <= 1'b0;
         av_d    <= 1'b0;
      end else begin
         av_meta <= data_avail;
         av_s    <= av_meta;
         av_d    <= av_s;
      end
   end

   assign rise = av_s & ~av_d;

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   state_t state;
   state_t state_nxt;
   logic   wr_en;
   logic   ovr_set;
   logic   full;

   assign full = (fifo_level == LVL_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         data_accept <= 1'b0;
      end else begin
         state       <= state_nxt;
         // Registered from the next state so accept is high exactly
         // while the state register reads HOLD.
         data_accept <= (state_nxt == S_HOLD);
      end
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise) begin
               if (!full) begin
                  wr_en     = 1'b1;
                  state_nxt = S_HOLD;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // The window closed while we were still waiting for room:
            // the readout moved on without acceptance, so the word is gone.
            if (!av_s) begin
               ovr_set   = 1'b1;
               state_nxt = S_IDLE;
            end else if (!full) begin
               wr_en     = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!av_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // clear wins over any capture or overrun decided above.
      if (clear) begin
         state_nxt = S_IDLE;
         wr_en     = 1'b0;
         ovr_set   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_count <= '0;
         overrun     <= 1'b0;
      end else if (clear) begin
         pixel_count <= '0;
         overrun     <= 1'b0;
      end else begin
         if (wr_en) begin
            pixel_count <= pixel_count + CNT_ONE;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Word FIFO. The head word stays in storage while it is serialized
   // and is popped only when its high byte leaves.
   // ------------------------------------------------------------------
   logic [15:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW-1:0] rd_ptr_inc;
   logic [15:0]        head_word;
   logic [15:0]        next_word;
   logic               phase_hi;
   logic               pop;

   assign rd_ptr_inc = rd_ptr + PTR_ONE;
   assign head_word  = mem[rd_ptr];
   assign next_word  = mem[rd_ptr_inc];
   assign pop        = out_valid & out_ready & phase_hi & ~clear;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         case ({wr_en, pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Byte serializer: low byte, then high byte, of the head word.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         phase_hi  <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
         phase_hi  <= 1'b0;
      end else if (!out_valid) begin
         // Only words already counted in the level are visible here; a
         // word being written this cycle is picked up next cycle.
         if (fifo_level != '0) begin
            out_valid <= 1'b1;
            out_data  <= head_word[7:0];
            phase_hi  <= 1'b0;
         end
      end else if (out_ready) begin
         if (!phase_hi) begin
            out_data <= head_word[15:8];
            phase_hi <= 1'b1;
         end else begin
            // Head is popped now; if another word sits behind it, show its
            // low byte straight away so a busy stream has no bubbles.
            phase_hi <= 1'b0;
            if (fifo_level >= LVL_TWO) begin
               out_data <= next_word[7:0];
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ccd_pixel_sink.sv
// tb_ccd_pixel_sink: randomized and directed stimulus for ccd_pixel_sink against a byte-queue reference model.
// A second instance with a 4-bit pixel counter shares every input and is used to observe counter wrap.
module tb_ccd_pixel_sink;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic [15:0] data_in;
   logic        data_avail;
   logic        out_ready;

   logic        data_accept;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [4:0]  fifo_level;
   logic [23:0] pixel_count;
   logic        overrun;

   logic        c4_data_accept;
   logic [7:0]  c4_out_data;
   logic        c4_out_valid;
   logic [4:0]  c4_fifo_level;
   logic [3:0]  c4_pixel_count;
   logic        c4_overrun;

   int          n_chk;
   int          n_fail;
   logic [7:0]  exp_q[$];
   int          model_cnt;
   int          bytes_taken;
   int          ready_mode;   // 0: hold low, 1: hold high, 2: random

   ccd_pixel_sink #(.FIFO_AW(4), .CNT_W(24)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .data_in     (data_in),
      .data_avail  (data_avail),
      .data_accept (data_accept),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fifo_level  (fifo_level),
      .pixel_count (pixel_count),
      .overrun     (overrun)
   );

   ccd_pixel_sink #(.FIFO_AW(4), .CNT_W(4)) u_dut_c4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .data_in     (data_in),
      .data_avail  (data_avail),
      .data_accept (c4_data_accept),
      .out_data    (c4_out_data),
      .out_valid   (c4_out_valid),
      .out_ready   (out_ready),
      .fifo_level  (c4_fifo_level),
      .pixel_count (c4_pixel_count),
      .overrun     (c4_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Host side: sole driver of out_ready, updated 2 time units after each edge.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   // Scoreboard: every byte taken by the host must be the next expected byte.
   // 32'h100 stands for "no byte was expected", which no real byte can equal.
   initial begin
      logic [31:0] exp_b;
      forever begin
         @(negedge clk);
         if (rst_n && !clear && out_valid && out_ready) begin
            bytes_taken++;
            if (exp_q.size() > 0) exp_b = 32'(exp_q.pop_front());
            else                  exp_b = 32'h100;
            chk("byte", 32'(out_data), exp_b);
         end
      end
   end

   task automatic expect_word(input logic [15:0] w);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      model_cnt++;
   endtask

   // One readout handshake: raise avail, wait for accept, hold, drop, wait for release.
   task automatic send_pixel(input logic [15:0] w, input int hold, input int limit, output bit got);
      int n;
      @(posedge clk); #1;
      data_in    = w;
      data_avail = 1'b1;
      got = 1'b0;
      n   = 0;
      while (!got && n < limit) begin
         @(negedge clk);
         if (data_accept) got = 1'b1;
         n++;
      end
      if (got) expect_word(w);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      data_avail = 1'b0;
      n = 0;
      while (data_accept && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("accept_release", 32'(data_accept), 32'd0);
   endtask

   task automatic drain();
      int n;
      ready_mode = 1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_level", 32'(fifo_level), 32'd0);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_cnt"},  32'(pixel_count),    32'(model_cnt) & 32'hFF_FFFF);
      chk({tag, "_cnt4"}, 32'(c4_pixel_count), 32'(model_cnt % 16));
   endtask

   initial begin
      bit          got;
      logic [15:0] w;
      int          n;
      int          b0;

      n_chk = 0; n_fail = 0; model_cnt = 0; bytes_taken = 0; ready_mode = 0;
      rst_n = 1'b0; clear = 1'b0; data_in = '0; data_avail = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_accept",  32'(data_accept), 32'd0);
      chk("rst_valid",   32'(out_valid),   32'd0);
      chk("rst_data",    32'(out_data),    32'd0);
      chk("rst_level",   32'(fifo_level),  32'd0);
      chk("rst_count",   32'(pixel_count), 32'd0);
      chk("rst_overrun", 32'(overrun),     32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_mode = 1;
      repeat (3) @(posedge clk);

      // 1: single pixel with exact handshake timing
      @(posedge clk); #1;
      data_in = 16'hA55A;
      data_avail = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1_accept_c2", 32'(data_accept), 32'd0);
      chk("t1_level_c2",  32'(fifo_level),  32'd0);
      @(negedge clk);
      chk("t1_accept_c3", 32'(data_accept), 32'd1);
      chk("t1_level_c3",  32'(fifo_level),  32'd1);
      chk("t1_valid_c3",  32'(out_valid),   32'd0);
      expect_word(16'hA55A);
      @(negedge clk);
      chk("t1_valid_c4",  32'(out_valid),   32'd1);
      chk("t1_lowbyte",   32'(out_data),    32'h5A);
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      data_avail = 1'b0;
      repeat (3) @(negedge clk);
      chk("t1_accept_m2", 32'(data_accept), 32'd1);
      @(negedge clk);
      chk("t1_accept_m3", 32'(data_accept), 32'd0);
      drain();
      check_counts("t1");

      // 2: burst against a stalled host
      ready_mode = 0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         send_pixel(16'($urandom), 0, 20, got);
         chk("t2_capture", 32'(got), 32'd1);
      end
      chk("t2_level_full", 32'(fifo_level), 32'd16);
      chk("t2_head_valid", 32'(out_valid),  32'd1);
      chk("t2_head_byte",  32'(out_data),   32'(exp_q[0]));
      w = 16'($urandom);
      @(posedge clk); #1;
      data_in = w;
      data_avail = 1'b1;
      repeat (8) @(negedge clk);
      chk("t2_parked_accept", 32'(data_accept), 32'd0);
      chk("t2_parked_level",  32'(fifo_level),  32'd16);
      // exactly two byte transfers release one FIFO slot
      @(posedge clk); #1;
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      ready_mode = 0;
      got = 1'b0;
      n = 0;
      while (!got && n < 10) begin
         @(negedge clk);
         if (data_accept) got = 1'b1;
         n++;
      end
      chk("t2_release_capture", 32'(got), 32'd1);
      if (got) expect_word(w);
      chk("t2_release_level", 32'(fifo_level), 32'd16);
      @(posedge clk); #1;
      data_avail = 1'b0;
      repeat (5) @(negedge clk);
      chk("t2_accept_drop", 32'(data_accept), 32'd0);

      // 3: window closes while parked on a full FIFO
      @(posedge clk); #1;
      data_in = 16'($urandom);
      data_avail = 1'b1;
      repeat (8) @(negedge clk);
      chk("t3_accept", 32'(data_accept), 32'd0);
      @(posedge clk); #1;
      data_avail = 1'b0;
      repeat (5) @(negedge clk);
      chk("t3_overrun", 32'(overrun),     32'd1);
      chk("t3_level",   32'(fifo_level),  32'd16);
      chk("t3_accept2", 32'(data_accept), 32'd0);
      check_counts("t3");

      // Throughput: 16 stored words leave as 32 bytes in 32 cycles
      @(posedge clk); #1;
      ready_mode = 1;
      #2;
      b0 = bytes_taken;
      repeat (32) @(posedge clk);
      #3;
      chk("thru_bytes", 32'(bytes_taken - b0), 32'd32);
      drain();
      send_pixel(16'h1234, 1, 20, got);
      chk("t3_idle_capture", 32'(got), 32'd1);
      drain();

      // 4: clear in the middle of HOLD with the window still open
      ready_mode = 0;
      @(posedge clk); #1;
      data_in = 16'hBEEF;
      data_avail = 1'b1;
      n = 0;
      while (!data_accept && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t4_hold", 32'(data_accept), 32'd1);
      pulse_clear();
      chk("t4_accept",  32'(data_accept), 32'd0);
      chk("t4_level",   32'(fifo_level),  32'd0);
      chk("t4_valid",   32'(out_valid),   32'd0);
      chk("t4_overrun", 32'(overrun),     32'd0);
      check_counts("t4");
      repeat (6) @(negedge clk);
      chk("t4_no_recapture", 32'(data_accept), 32'd0);
      chk("t4_level_idle",   32'(fifo_level),  32'd0);
      @(posedge clk); #1;
      data_avail = 1'b0;
      repeat (4) @(posedge clk);
      ready_mode = 1;
      send_pixel(16'hC0DE, 0, 20, got);
      chk("t4_recapture", 32'(got), 32'd1);
      drain();

      // 6: 4-bit counter instance wraps after 16 words
      pulse_clear();
      for (int i = 0; i < 15; i++) begin
         send_pixel(16'($urandom), 0, 20, got);
         chk("t6_capture", 32'(got), 32'd1);
      end
      chk("t6_cnt4_max", 32'(c4_pixel_count), 32'd15);
      send_pixel(16'($urandom), 0, 20, got);
      chk("t6_cnt4_wrap", 32'(c4_pixel_count), 32'd0);
      chk("t6_cnt_full",  32'(pixel_count),    32'd16);
      drain();

      // Random traffic with a random host
      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         send_pixel(16'($urandom), $urandom_range(0, 3), 300, got);
         chk("rand_capture", 32'(got), 32'd1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();
      check_counts("rand");
      chk("rand_overrun", 32'(overrun), 32'd0);

      // 5: asynchronous reset during a byte transfer
      ready_mode = 0;
      send_pixel(16'h7E81, 0, 20, got);
      send_pixel(16'h3C96, 0, 20, got);
      @(posedge clk); #1;
      ready_mode = 1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      data_avail = 1'b0;
      #1;
      chk("t5_accept",  32'(data_accept), 32'd0);
      chk("t5_valid",   32'(out_valid),   32'd0);
      chk("t5_data",    32'(out_data),    32'd0);
      chk("t5_level",   32'(fifo_level),  32'd0);
      chk("t5_overrun", 32'(overrun),     32'd0);
      check_counts("t5");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      send_pixel(16'h55AA, 0, 20, got);
      chk("t5_resume_capture", 32'(got), 32'd1);
      send_pixel(16'h0FF0, 2, 20, got);
      chk("t5_resume_capture2", 32'(got), 32'd1);
      drain();
      check_counts("t5_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
